// File: rtl/gpio_reg_arbiter_pkg.sv
// Shared definitions for the GPIO register-port arbiter: FSM encodings,
// requester ids, GPIO register word addresses and the register-port bundle.
package gpio_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  typedef enum logic {
    ID_M0 = 1'b0,
    ID_M1 = 1'b1
  } req_id_t;

  // GPIO register word addresses (addr[4:2])
  localparam logic [2:0] ADDR_TRISTATE = 3'd0;
  localparam logic [2:0] ADDR_DATAREG  = 3'd1;
  localparam logic [2:0] ADDR_PINSTATE = 3'd2;
  localparam logic [2:0] ADDR_INT_MASK = 3'd3;

  typedef struct packed {
    logic [2:0]  addr;
    logic        r_wn;
    logic [3:0]  wben;
    logic [31:0] wdata;
  } xfer_t;

  // Register-port values while nothing is being accessed
  localparam xfer_t PORT_IDLE = '{addr: 3'd0, r_wn: 1'b1, wben: 4'h0, wdata: 32'h0};

  function automatic req_id_t other_id(input req_id_t id);
    return (id == ID_M0) ? ID_M1 : ID_M0;
  endfunction

endpackage

// File: rtl/gpio_reg_arbiter_if.sv
// One requester's req/ack bus towards the GPIO register-port arbiter.
interface gpio_reg_arbiter_if;
  logic        req;
  logic [2:0]  addr;
  logic        r_wn;
  logic [3:0]  wben;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, r_wn, wben, wdata, input ack, rdata);
  modport slave  (input req, addr, r_wn, wben, wdata, output ack, rdata);
endinterface

// File: rtl/gpio_reg_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module gpio_reg_arbiter_rr_arb2
  import gpio_reg_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output req_id_t    grant,
  output logic       valid
);

  // Combinational grant selection
  always_comb begin
    valid = |req;
    grant = ID_M0;
    if (req == 2'b11) begin
      grant = other_id(last_grant);
    end else if (req[1]) begin
      grant = ID_M1;
    end
  end

endmodule

// File: rtl/gpio_reg_arbiter.sv
// Shares the GPIO register-file port between two requesters. Fields of the
// winner are latched at grant; every output comes straight from a flop.
//
//  state     | meaning
//  ST_IDLE   | port at idle values, arbitrating between m0/m1 requests
//  ST_ACCESS | winner's transfer on the port (1 cycle write, RD_LATENCY+1 read)
//  ST_ACK    | one-cycle ack to the winner, port back at idle values
module gpio_reg_arbiter
  import gpio_reg_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  gpio_reg_arbiter_if.slave    m0,
  gpio_reg_arbiter_if.slave    m1,
  output logic [2:0]           reg_addr,
  output logic                 reg_r_wn,
  output logic [3:0]           reg_wben,
  output logic [31:0]          reg_wdata,
  input  logic [31:0]          reg_rdata,
  output logic                 busy
);

  localparam logic [1:0] RD_CNT = 2'(RD_LATENCY);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  req_id_t     win_q, win_d;
  req_id_t     lg_q, lg_d;
  xfer_t       port_q, port_d;
  logic [1:0]  ack_q, ack_d;
  logic [31:0] rd0_q, rd1_q;
  logic        busy_q;
  logic        cap;
  req_id_t     arb_grant;
  logic        arb_valid;
  xfer_t       m0_x, m1_x;

  assign m0_x = '{addr: m0.addr, r_wn: m0.r_wn, wben: m0.wben, wdata: m0.wdata};
  assign m1_x = '{addr: m1.addr, r_wn: m1.r_wn, wben: m1.wben, wdata: m1.wdata};

  gpio_reg_arbiter_rr_arb2 u_arb (
    .req        ({m1.req, m0.req}),
    .last_grant (lg_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // Next-state, next port values, ack pulse and read-capture strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    lg_d    = lg_q;
    port_d  = port_q;
    ack_d   = 2'b00;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        port_d = PORT_IDLE;
        if (arb_valid) begin
          state_d = ST_ACCESS;
          win_d   = arb_grant;
          lg_d    = arb_grant;
          port_d  = (arb_grant == ID_M1) ? m1_x : m0_x;
          if (port_d.r_wn) begin
            port_d.wben = 4'h0;
            cnt_d       = RD_CNT;
          end else begin
            cnt_d = 2'd0;
          end
        end
      end
      ST_ACCESS: begin
        // write enables live for the first access cycle only
        port_d.wben = 4'h0;
        if (cnt_q == 2'd0) begin
          state_d = ST_ACK;
          port_d  = PORT_IDLE;
          cap     = port_q.r_wn;
          ack_d   = (win_q == ID_M1) ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        port_d  = PORT_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        port_d  = PORT_IDLE;
      end
    endcase
  end

  // State, port, ack and read-data registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      win_q   <= ID_M0;
      lg_q    <= ID_M1;
      port_q  <= PORT_IDLE;
      ack_q   <= 2'b00;
      rd0_q   <= 32'h0;
      rd1_q   <= 32'h0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      lg_q    <= lg_d;
      port_q  <= port_d;
      ack_q   <= ack_d;
      busy_q  <= (state_d != ST_IDLE);
      if (cap && (win_q == ID_M0)) rd0_q <= reg_rdata;
      if (cap && (win_q == ID_M1)) rd1_q <= reg_rdata;
    end
  end

  assign reg_addr  = port_q.addr;
  assign reg_r_wn  = port_q.r_wn;
  assign reg_wben  = port_q.wben;
  assign reg_wdata = port_q.wdata;
  assign busy      = busy_q;
  assign m0.ack    = ack_q[0];
  assign m1.ack    = ack_q[1];
  assign m0.rdata  = rd0_q;
  assign m1.rdata  = rd1_q;

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Bench for gpio_reg_arbiter: dut0 has RD_LATENCY=0, dut1 RD_LATENCY=1.
// A transaction-level model predicts every registered output each cycle;
// directed scenarios add literal expectations on latency, order and data.
module tb_gpio_reg_arbiter;

  typedef struct packed {
    logic        req;
    logic [2:0]  addr;
    logic        r_wn;
    logic [3:0]  wben;
    logic [31:0] wdata;
  } drv_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  gpio_reg_arbiter_if d0_m0 ();
  gpio_reg_arbiter_if d0_m1 ();
  gpio_reg_arbiter_if d1_m0 ();
  gpio_reg_arbiter_if d1_m1 ();

  drv_t drv [2][2];
  assign {d0_m0.req, d0_m0.addr, d0_m0.r_wn, d0_m0.wben, d0_m0.wdata} = drv[0][0];
  assign {d0_m1.req, d0_m1.addr, d0_m1.r_wn, d0_m1.wben, d0_m1.wdata} = drv[0][1];
  assign {d1_m0.req, d1_m0.addr, d1_m0.r_wn, d1_m0.wben, d1_m0.wdata} = drv[1][0];
  assign {d1_m1.req, d1_m1.addr, d1_m1.r_wn, d1_m1.wben, d1_m1.wdata} = drv[1][1];

  logic [3:0]       ack_all;
  logic [3:0][31:0] rd_all;
  assign ack_all = {d1_m1.ack, d1_m0.ack, d0_m1.ack, d0_m0.ack};
  assign rd_all  = {d1_m1.rdata, d1_m0.rdata, d0_m1.rdata, d0_m0.rdata};

  logic [2:0]  r0_addr, r1_addr;
  logic        r0_rwn, r1_rwn, r0_busy, r1_busy;
  logic [3:0]  r0_wben, r1_wben;
  logic [31:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata;

  gpio_reg_arbiter #(.RD_LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .m0(d0_m0), .m1(d0_m1),
    .reg_addr(r0_addr), .reg_r_wn(r0_rwn), .reg_wben(r0_wben),
    .reg_wdata(r0_wdata), .reg_rdata(r0_rdata), .busy(r0_busy));

  gpio_reg_arbiter #(.RD_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .m0(d1_m0), .m1(d1_m1),
    .reg_addr(r1_addr), .reg_r_wn(r1_rwn), .reg_wben(r1_wben),
    .reg_wdata(r1_wdata), .reg_rdata(r1_rdata), .busy(r1_busy));

  function automatic logic [31:0] pre(input int a);
    case (a)
      1:       return 32'h1234_5678;
      2:       return 32'h1111_1111;
      default: return 32'h5A00_0000 + 32'(a);
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Register files behind each DUT: dut0 reads combinationally, dut1 one cycle late
  logic [31:0] mem [2][8];
  assign r0_rdata = mem[0][r0_addr];
  always @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < 8; a++) begin
        mem[0][a] <= pre(a);
        mem[1][a] <= pre(a);
      end
    end else begin
      if (r0_wben != 4'h0) mem[0][r0_addr] <= merge(mem[0][r0_addr], r0_wdata, r0_wben);
      if (r1_wben != 4'h0) mem[1][r1_addr] <= merge(mem[1][r1_addr], r1_wdata, r1_wben);
    end
    r1_rdata <= mem[1][r1_addr];
  end

  // Transaction-level model: each grant occupies the port for a known number
  // of cycles (access length + ack); outputs follow from where we are in it.
  int          rem   [2];
  logic        lg    [2];
  logic        win   [2];
  drv_t        cur   [2];
  logic [1:0]  e_ack [2];
  logic [31:0] e_rd  [2][2];
  logic [2:0]  e_addr[2];
  logic        e_rwn [2];
  logic [3:0]  e_wben[2];
  logic [31:0] e_wdata[2];
  logic        e_busy[2];
  logic [31:0] mmem  [2][8];

  task automatic model_step();
    logic [1:0] rq;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        rem[d] = 0; lg[d] = 1'b1; win[d] = 1'b0; e_ack[d] = 2'b00;
        e_rd[d][0] = 32'h0; e_rd[d][1] = 32'h0;
        e_addr[d] = 3'd0; e_rwn[d] = 1'b1; e_wben[d] = 4'h0; e_wdata[d] = 32'h0; e_busy[d] = 1'b0;
        for (int a = 0; a < 8; a++) mmem[d][a] = pre(a);
      end else if (rem[d] == 0) begin
        rq = {drv[d][1].req, drv[d][0].req};
        e_ack[d] = 2'b00;
        if (rq != 2'b00) begin
          win[d] = (rq == 2'b11) ? ~lg[d] : rq[1];
          lg[d]  = win[d];
          cur[d] = drv[d][win[d]];
          rem[d] = (cur[d].r_wn ? d + 1 : 1) + 1;
          e_addr[d] = cur[d].addr; e_rwn[d] = cur[d].r_wn;
          e_wben[d] = cur[d].r_wn ? 4'h0 : cur[d].wben;
          e_wdata[d] = cur[d].wdata; e_busy[d] = 1'b1;
        end
      end else begin
        rem[d]--;
        if (rem[d] == 1) begin
          if (cur[d].r_wn) e_rd[d][win[d]] = mmem[d][cur[d].addr];
          else mmem[d][cur[d].addr] = merge(mmem[d][cur[d].addr], cur[d].wdata, cur[d].wben);
          e_ack[d][win[d]] = 1'b1;
          e_addr[d] = 3'd0; e_rwn[d] = 1'b1; e_wben[d] = 4'h0; e_wdata[d] = 32'h0;
        end else if (rem[d] == 0) begin
          e_ack[d] = 2'b00; e_busy[d] = 1'b0;
        end else begin
          e_wben[d] = 4'h0;
        end
      end
    end
  endtask

  always @(posedge clock) model_step();

  int vectors = 0;
  int miscompares = 0;
  int n_left [2][2];
  int start_cyc [2][2];
  int ack_cyc [2][2];
  int acks_seen [2][2];
  int wcnt [2];
  int order_q [$];

  task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, got, exp);
    end
  endtask

  task automatic lit(string nm, logic [31:0] got, logic [31:0] exp);
    chk(nm, 9, got, exp);
  endtask

  task automatic compare_all();
    chk("ack_m0", 0, {31'b0, ack_all[0]}, {31'b0, e_ack[0][0]});
    chk("ack_m1", 0, {31'b0, ack_all[1]}, {31'b0, e_ack[0][1]});
    chk("ack_m0", 1, {31'b0, ack_all[2]}, {31'b0, e_ack[1][0]});
    chk("ack_m1", 1, {31'b0, ack_all[3]}, {31'b0, e_ack[1][1]});
    chk("rdata_m0", 0, rd_all[0], e_rd[0][0]);
    chk("rdata_m1", 0, rd_all[1], e_rd[0][1]);
    chk("rdata_m0", 1, rd_all[2], e_rd[1][0]);
    chk("rdata_m1", 1, rd_all[3], e_rd[1][1]);
    chk("reg_addr", 0, {29'b0, r0_addr}, {29'b0, e_addr[0]});
    chk("reg_addr", 1, {29'b0, r1_addr}, {29'b0, e_addr[1]});
    chk("reg_r_wn", 0, {31'b0, r0_rwn}, {31'b0, e_rwn[0]});
    chk("reg_r_wn", 1, {31'b0, r1_rwn}, {31'b0, e_rwn[1]});
    chk("reg_wben", 0, {28'b0, r0_wben}, {28'b0, e_wben[0]});
    chk("reg_wben", 1, {28'b0, r1_wben}, {28'b0, e_wben[1]});
    chk("reg_wdata", 0, r0_wdata, e_wdata[0]);
    chk("reg_wdata", 1, r1_wdata, e_wdata[1]);
    chk("busy", 0, {31'b0, r0_busy}, {31'b0, e_busy[0]});
    chk("busy", 1, {31'b0, r1_busy}, {31'b0, e_busy[1]});
  endtask

  // One clock: requester reaction to acks just after the edge, then compare mid-cycle
  task automatic tick();
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      if ((d == 0 ? r0_wben : r1_wben) != 4'h0) wcnt[d]++;
      for (int m = 0; m < 2; m++) begin
        if (ack_all[d*2+m]) begin
          acks_seen[d][m]++;
          ack_cyc[d][m] = cyc;
          if (d == 1) order_q.push_back(m);
          if (n_left[d][m] > 0) begin
            n_left[d][m]--;
            if (n_left[d][m] == 0) drv[d][m].req = 1'b0;
          end
        end
      end
    end
    @(negedge clock);
    compare_all();
  endtask

  task automatic launch(int d, int m, int n, logic rw, logic [2:0] a, logic [3:0] be,
                        logic [31:0] wd);
    drv[d][m] = '{req: 1'b1, addr: a, r_wn: rw, wben: be, wdata: wd};
    n_left[d][m] = n;
    start_cyc[d][m] = cyc;
  endtask

  task automatic wait_done(int d, int budget);
    int  k;
    logic done;
    k = 0;
    do begin
      tick();
      k++;
      done = (n_left[d][0] == 0) && (n_left[d][1] == 0) && !(d == 0 ? r0_busy : r1_busy);
    end while (!done && k < budget);
    lit("wait_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    int a0, a1, k;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wcnt[d] = 0;
      for (int m = 0; m < 2; m++) begin
        drv[d][m] = '{req: 1'b0, addr: 3'd0, r_wn: 1'b1, wben: 4'h0, wdata: 32'h0};
        n_left[d][m] = 0; start_cyc[d][m] = 0; ack_cyc[d][m] = 0; acks_seen[d][m] = 0;
      end
    end

    // Reset held with both requests high
    drv[1][0].req = 1'b1; drv[1][1].req = 1'b1;
    repeat (5) tick();
    lit("t1_busy", {31'b0, r1_busy}, 32'd0);
    lit("t1_wben", {28'b0, r1_wben}, 32'd0);
    lit("t1_rwn", {31'b0, r1_rwn}, 32'd1);
    lit("t1_acks", {28'b0, ack_all}, 32'd0);
    drv[1][0].req = 1'b0; drv[1][1].req = 1'b0;
    reset = 1'b0;
    tick();

    // M0 full-word write
    wcnt[1] = 0;
    launch(1, 0, 1, 1'b0, 3'd0, 4'hF, 32'h0000_A5A5);
    wait_done(1, 10);
    lit("t2_ack_latency", 32'(ack_cyc[1][0] - start_cyc[1][0]), 32'd2);
    lit("t2_wben_cycles", 32'(wcnt[1]), 32'd1);
    lit("t2_m1_no_ack", 32'(acks_seen[1][1]), 32'd0);

    // M1 read with one cycle of register latency
    a0 = acks_seen[1][0];
    launch(1, 1, 1, 1'b1, 3'd1, 4'hF, 32'h0);
    wait_done(1, 10);
    lit("t3_ack_latency", 32'(ack_cyc[1][1] - start_cyc[1][1]), 32'd3);
    lit("t3_rdata", rd_all[3], 32'h1234_5678);
    lit("t3_m0_no_ack", 32'(acks_seen[1][0] - a0), 32'd0);

    // Simultaneous held requests alternate
    order_q.delete();
    a0 = acks_seen[1][0]; a1 = acks_seen[1][1];
    launch(1, 0, 3, 1'b0, 3'd2, 4'b0101, 32'hDEAD_BEEF);
    launch(1, 1, 3, 1'b1, 3'd2, 4'h0, 32'h0);
    wait_done(1, 60);
    lit("t4_m0_acks", 32'(acks_seen[1][0] - a0), 32'd3);
    lit("t4_m1_acks", 32'(acks_seen[1][1] - a1), 32'd3);
    lit("t4_order_len", 32'(order_q.size()), 32'd6);
    for (int i = 0; i < order_q.size(); i++) lit("t4_order", 32'(order_q[i]), 32'(i % 2));
    lit("t4_rdata", rd_all[3], 32'h11AD_11EF);

    // Reset in the ACCESS cycle of an M1 write
    launch(1, 1, 1, 1'b0, 3'd3, 4'hF, 32'hCAFE_F00D);
    k = 0;
    do begin tick(); k++; end while (r1_wben == 4'h0 && k < 8);
    lit("t5_wben_seen", {28'b0, r1_wben}, 32'hF);
    reset = 1'b1;
    drv[1][1].req = 1'b0; n_left[1][1] = 0;
    a1 = acks_seen[1][1];
    tick();
    lit("t5_wben_after", {28'b0, r1_wben}, 32'd0);
    lit("t5_busy_after", {31'b0, r1_busy}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    lit("t5_no_ack", 32'(acks_seen[1][1] - a1), 32'd0);
    order_q.delete();
    launch(1, 0, 1, 1'b1, 3'd0, 4'h0, 32'h0);
    launch(1, 1, 1, 1'b1, 3'd2, 4'h0, 32'h0);
    wait_done(1, 20);
    lit("t5_order_len", 32'(order_q.size()), 32'd2);
    if (order_q.size() > 0) lit("t5_first_grant", 32'(order_q[0]), 32'd0);
    lit("t5_rdata_m1", rd_all[3], 32'h1111_1111);

    // Zero-enable write and zero-latency read on dut0
    wcnt[0] = 0;
    launch(0, 0, 1, 1'b0, 3'd1, 4'h0, 32'hFFFF_FFFF);
    wait_done(0, 10);
    lit("t6_ack_latency", 32'(ack_cyc[0][0] - start_cyc[0][0]), 32'd2);
    lit("t6_wben_cycles", 32'(wcnt[0]), 32'd0);
    launch(0, 1, 1, 1'b1, 3'd1, 4'h0, 32'h0);
    wait_done(0, 10);
    lit("t6_rd_latency", 32'(ack_cyc[0][1] - start_cyc[0][1]), 32'd2);
    lit("t6_rdata", rd_all[1], 32'h1234_5678);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
